ahb_lite_mem_slave: RTL and testbench
=====================================

# ahb_lite_mem_slave

Parametrised AHB-Lite memory slave that supersedes the fixed-width 16-bit-address/32-bit-data slave in the AHB verification environment. It holds a register-array memory with configurable data width, depth and wait states, and byte-lane write strobing derived from HSIZE/HADDR. It returns a two-cycle ERROR response for out-of-range, oversized or misaligned transfers. It sits behind the AHB decoder and is driven by the same master bench, bind-in properties and coverage collector as its predecessor.

## Interface
Parameters:
- ADDR_WIDTH, 16: HADDR width.
- DATA_WIDTH, 32: HWDATA/HRDATA width. Legal values are 32 and 64. BYTES = DATA_WIDTH/8; LSB = log2(BYTES).
- DEPTH_WORDS, 1024: number of DATA_WIDTH words. Valid byte range is 0 to DEPTH_WORDS*BYTES-1.
- WAIT_STATES, 0: number of HREADYOUT=0 cycles inserted before each OKAY completion. Range 0 to 15.

Ports:
- HCLK, in, 1: the single clock; all logic is on the rising edge.
- HRESET, in, 1: synchronous, active-high reset.
- HSEL, in, 1: slave select.
- HADDR, in, ADDR_WIDTH: byte address.
- HTRANS, in, 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE, in, 1: 1 = write.
- HSIZE, in, 3: transfer size, 2^HSIZE bytes.
- HBURST, in, 3: accepted but ignored; each beat is decoded independently.
- HPROT, in, 4: accepted but ignored.
- HWDATA, in, DATA_WIDTH: write data, valid during the data phase.
- HREADY, in, 1: bus ready (the muxed HREADYOUT).
- HRDATA, out, DATA_WIDTH: read data.
- HREADYOUT, out, 1: slave ready.
- HRESP, out, 1: 0 = OKAY, 1 = ERROR.

## Operation
- Accept: an address phase is accepted when HSEL & HREADY & HTRANS[1] on a rising edge. The slave registers addr, write, size and an error flag.
- Error flag is set if any of the following holds:
  - addr >= DEPTH_WORDS*BYTES;
  - HSIZE > LSB;
  - addr is not aligned to 2^HSIZE.
- IDLE, BUSY, or HSEL=0: no transfer is accepted. The next cycle is OKAY with HREADYOUT=1 and zero wait.
- FSM states are IDLE, WAIT, LAST, ERR1 and ERR2.
  - IDLE -> ERR1 on an accepted transfer with the error flag set.
  - IDLE -> WAIT on an accepted transfer when WAIT_STATES > 0.
  - IDLE -> LAST on an accepted transfer when WAIT_STATES = 0.
  - WAIT: a counter loads WAIT_STATES-1 on entry and decrements each cycle. WAIT -> LAST when the counter reaches 0.
  - LAST: on the next edge, return to IDLE, or re-enter WAIT/LAST/ERR1 if a new transfer is accepted on that edge (pipelined back-to-back).
  - ERR1 -> ERR2 unconditionally.
  - ERR2 behaves like LAST: back to IDLE, or straight to the next transfer if one is accepted.
- Outputs by state:
  - WAIT: HREADYOUT=0, HRESP=0.
  - LAST: HREADYOUT=1, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - IDLE: HREADYOUT=1, HRESP=0.
- Write commit: on the LAST-cycle edge only. Bytes are written under byte-lane strobes:
  - lane k is enabled for k in [addr[LSB-1:0], addr[LSB-1:0] + 2^size - 1];
  - the lane takes HWDATA[8k+7:8k];
  - memory is little-endian.
- Read:
  - In LAST, HRDATA = mem[addr >> LSB], the full word. The master selects lanes.
  - In every other state HRDATA = 0.
  - An errored read returns 0.
- Errored transfers never modify memory.
- Hazard: a write followed immediately by a read of the same word returns the new data. The write commits on the same edge the read's address phase is sampled, and the read is taken from the array in its data phase.
- Reset:
  - State goes to IDLE, the wait counter to 0, and all registered address-phase fields are cleared.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - Memory contents are not cleared.
  - Reset asserted during WAIT, LAST or ERR1 aborts the transfer, and a pending write is not committed.

## Timing
- Address phase is sampled at edge N.
- With WAIT_STATES=W, the OKAY completion cycle falls in cycles N+1 to N+1+W. HREADYOUT is 0 for W cycles, then 1 for one cycle.
- Error: HRESP=1 in cycles N+1 and N+2. HREADYOUT is 0 then 1. No wait states are applied.
- Throughput with W=0 is one transfer per cycle.
- The slave must not accept a new address phase while HREADY=0.
- All outputs are decoded from registered state. There is no combinational path from the inputs to HREADYOUT or HRESP.

## Test plan
- Reset: with DATA_WIDTH=32 and W=0, hold HRESET for 2 cycles -> HREADYOUT=1, HRESP=0, HRDATA=0. Then check that a NONSEQ read at 0x0000 completes OKAY in 1 cycle.
- Byte lanes: word write 0x11223344 @0x0010, then byte write 0xAA000000 @0x0013 (HSIZE=0), then word read @0x0010 -> 0xAA223344 OKAY. Then halfword write 0x0000BEEF @0x0010 (HSIZE=1), then word read -> 0xAA22BEEF.
- Back-to-back with W=0: NONSEQ write 0xCAFEF00D @0x0100 immediately followed by NONSEQ read @0x0100 -> read data phase returns 0xCAFEF00D. HREADYOUT stays 1 throughout.
- Wait states with W=3: read @0x0004 -> HREADYOUT=0 for 3 cycles, then 1 with correct data. A 4-beat INCR write shows 4 wait groups, and all 4 words read back correctly.
- Errors with DEPTH_WORDS=1024:
  - write @0x1000 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, and memory @0x0000 is unchanged;
  - word read @0x0002 (misaligned) -> ERROR, HRDATA=0;
  - HSIZE=3 with DATA_WIDTH=32 -> ERROR.
- Reset mid-write with W=4: assert HRESET in the second wait cycle of a write of 0xDEADBEEF @0x0020 -> the next cycle shows HREADYOUT=1, HRESP=0, and a later read @0x0020 returns the old value.

Source files
------------

// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: parametrised AHB-Lite memory slave.
// Register-array memory with byte-lane write strobes, a configurable number
// of wait states before each OKAY completion, and a two-cycle ERROR
// response for out-of-range, oversized or misaligned transfers.
//
// Handshake: an address phase is taken on a rising edge when
// HSEL & HREADY & HTRANS[1] and the slave is in a state that can start a
// transfer (IDLE, LAST, ERR2). The data phase completes on the first edge
// where HREADYOUT=1. HWDATA must be held valid for the whole data phase.
// Outputs are decoded from registered state only.
module ahb_lite_mem_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [2:0]            o_dbg_state
);

  localparam int          BYTES     = DATA_WIDTH / 8;
  localparam int          LSB       = $clog2(BYTES);
  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * BYTES);
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_wait_cnt;
  logic [3:0]            w_next_wait_cnt;

  // Registered address-phase fields
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic                  r_err;

  logic                  w_can_start;
  logic                  w_take;
  logic                  w_err;
  logic                  w_misaligned;
  logic [LSB-1:0]        w_align_mask;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      w_word_idx;
  logic [31:0]           w_lane_off;
  logic [31:0]           w_lane_cnt;
  logic [BYTES-1:0]      w_lane_en;

  // Burst type, protection and the BUSY/IDLE distinction carry no meaning here.
  logic                  w_unused_inputs;
  assign w_unused_inputs = ^{HBURST, HPROT, HTRANS[0]};

  // A new transfer can only start when no data phase is stalling the bus.
  assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_LAST) || (r_state == ST_ERR2);
  assign w_take      = HSEL & HREADY & HTRANS[1] & w_can_start;

  // Alignment mask: low address bits that must be zero for a 2^HSIZE access.
  always_comb begin
    w_align_mask = '0;
    for (int i = 0; i < LSB; i++) begin
      w_align_mask[i] = (32'(HSIZE) > 32'(i));
    end
  end

  assign w_misaligned = |(HADDR[LSB-1:0] & w_align_mask);
  assign w_err        = (32'(HADDR) >= MEM_BYTES) ||
                        (32'(HSIZE) > 32'(LSB))   ||
                        w_misaligned;

  // State register and wait counter.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  // Next-state logic; LAST and ERR2 chain straight into a pipelined transfer.
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    case (r_state)
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_next_state = ST_LAST;
        end else begin
          w_next_wait_cnt = r_wait_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        w_next_state = ST_ERR2;
      end
      default: begin
        if (w_take) begin
          if (w_err) begin
            w_next_state = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_next_state    = ST_WAIT;
            w_next_wait_cnt = WAIT_LOAD;
          end else begin
            w_next_state = ST_LAST;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
    endcase
  end

  // Capture address-phase fields whenever a transfer is taken.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_err   <= 1'b0;
    end else if (w_take) begin
      r_addr  <= HADDR;
      r_write <= HWRITE;
      r_size  <= HSIZE;
      r_err   <= w_err;
    end
  end

  // Byte-lane enables: lanes [offset, offset + 2^size - 1], little-endian.
  assign w_word_idx = IDX_W'(r_addr >> LSB);
  assign w_lane_off = 32'(r_addr[LSB-1:0]);
  assign w_lane_cnt = 32'd1 << r_size;

  always_comb begin
    w_lane_en = '0;
    for (int k = 0; k < BYTES; k++) begin
      w_lane_en[k] = (32'(k) >= w_lane_off) && (32'(k) < (w_lane_off + w_lane_cnt));
    end
  end

  // Write commit on the completion edge; reset on that edge aborts it.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (r_state == ST_LAST) && r_write && !r_err) begin
      for (int k = 0; k < BYTES; k++) begin
        if (w_lane_en[k]) begin
          r_mem[w_word_idx][8*k +: 8] <= HWDATA[8*k +: 8];
        end
      end
    end
  end

  // Output decode from registered state; read data comes straight from the array.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (r_state)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
      end
      ST_LAST: begin
        HRDATA = r_mem[w_word_idx];
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HRESP = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Testbench for ahb_lite_mem_slave: three instances (0, 3 and 4 wait states)
// share one bus; only the selected instance sees HSEL. A memory model and
// expected-result queues form the scoreboard.
module tb_ahb_lite_mem_slave;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- bus ----------------
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [DW-1:0] hwdata;
  int            sel;

  logic [DW-1:0] rdata [3];
  logic          rdy   [3];
  logic          resp  [3];
  logic [2:0]    dbg   [3];

  logic [DW-1:0] rdata_m;
  logic          rdy_m;
  logic          resp_m;

  ahb_lite_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_w0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel == 0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(rdy[0]), .HRDATA(rdata[0]), .HREADYOUT(rdy[0]), .HRESP(resp[0]),
    .o_dbg_state(dbg[0]));

  ahb_lite_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_w3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel == 1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(rdy[1]), .HRDATA(rdata[1]), .HREADYOUT(rdy[1]), .HRESP(resp[1]),
    .o_dbg_state(dbg[1]));

  ahb_lite_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(4)) u_w4 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel == 2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(rdy[2]), .HRDATA(rdata[2]), .HREADYOUT(rdy[2]), .HRESP(resp[2]),
    .o_dbg_state(dbg[2]));

  always_comb begin
    case (sel)
      1:       begin rdata_m = rdata[1]; rdy_m = rdy[1]; resp_m = resp[1]; end
      2:       begin rdata_m = rdata[2]; rdy_m = rdy[2]; resp_m = resp[2]; end
      default: begin rdata_m = rdata[0]; rdy_m = rdy[0]; resp_m = resp[0]; end
    endcase
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic          exp_err_q[$];
  logic          exp_chk_q[$];
  logic [DW-1:0] model_mem [DEPTH];

  typedef struct {
    logic [1:0]    trans;
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
    logic          has_exp;
    logic [DW-1:0] exp_v;
  } beat_t;

  beat_t beats[$];

  task automatic add_beat(input logic [1:0] trans, input logic wr, input logic [AW-1:0] addr,
                          input logic [2:0] size, input logic [DW-1:0] wdata,
                          input logic has_exp, input logic [DW-1:0] exp_v);
    beat_t b;
    b.trans = trans; b.wr = wr; b.addr = addr; b.size = size;
    b.wdata = wdata; b.has_exp = has_exp; b.exp_v = exp_v;
    beats.push_back(b);
  endtask

  // Expected outcome of an accepted address phase, in issue order.
  task automatic push_expect(input beat_t b);
    int            nb, idx, off;
    logic          err;
    logic [DW-1:0] ev;
    nb  = 1 << b.size;
    err = (int'(b.addr) >= DEPTH * 4) || (b.size > 3'd2) || ((int'(b.addr) % nb) != 0);
    idx = int'(b.addr) / 4;
    off = int'(b.addr) % 4;
    if (err) begin
      exp_err_q.push_back(1'b1);
      exp_q.push_back('0);
      exp_chk_q.push_back(!b.wr);
    end else if (b.wr) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= off && k < off + nb) model_mem[idx][8*k +: 8] = b.wdata[8*k +: 8];
      end
      exp_err_q.push_back(1'b0);
      exp_q.push_back('0);
      exp_chk_q.push_back(1'b0);
    end else begin
      ev = b.has_exp ? b.exp_v : model_mem[idx];
      exp_err_q.push_back(1'b0);
      exp_q.push_back(ev);
      exp_chk_q.push_back(!$isunknown(ev));
    end
  endtask

  // ---------------- driver ----------------
  task automatic present_next(output logic presenting, output beat_t cur);
    if (beats.size() > 0) begin
      cur    = beats.pop_front();
      haddr  = cur.addr;
      htrans = cur.trans;
      hwrite = cur.wr;
      hsize  = cur.size;
      presenting = 1'b1;
    end else begin
      cur    = '{default: '0};
      htrans = 2'b00;
      presenting = 1'b0;
    end
  endtask

  // Drives the queued beats pipelined; called and returns at posedge+1.
  task automatic run_beats(input string name);
    int            cyc, waits, wexp;
    logic          dp, acc, done_cyc, presenting, e, c;
    logic [DW-1:0] d;
    beat_t         cur;
    wexp  = (sel == 0) ? 0 : (sel == 1) ? 3 : 4;
    dp    = 1'b0;
    waits = 0;
    cyc   = 0;
    present_next(presenting, cur);
    while ((presenting || dp) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      acc      = presenting && cur.trans[1] && rdy_m;
      done_cyc = 1'b0;
      if (dp) begin
        if (rdy_m) begin
          e = exp_err_q.pop_front();
          d = exp_q.pop_front();
          c = exp_chk_q.pop_front();
          checks++;
          if (resp_m !== e) begin
            errors++;
            $display("FAIL %s resp: got %0b want %0b", name, resp_m, e);
          end
          checks++;
          if (waits != (e ? 1 : wexp)) begin
            errors++;
            $display("FAIL %s wait_cycles: got %0d want %0d", name, waits, (e ? 1 : wexp));
          end
          if (c) begin
            checks++;
            if (rdata_m !== d) begin
              errors++;
              $display("FAIL %s rdata: got %h want %h", name, rdata_m, d);
            end
          end
          done_cyc = 1'b1;
        end else begin
          waits++;
          checks++;
          if (resp_m !== exp_err_q[0]) begin
            errors++;
            $display("FAIL %s stall_resp: got %0b want %0b", name, resp_m, exp_err_q[0]);
          end
        end
      end else begin
        checks++;
        if (rdy_m !== 1'b1 || resp_m !== 1'b0 || rdata_m !== '0) begin
          errors++;
          $display("FAIL %s idle_outputs: got rdy=%0b resp=%0b rdata=%h want 1 0 0",
                   name, rdy_m, resp_m, rdata_m);
        end
      end
      @(posedge clk);
      #1;
      if (done_cyc) dp = 1'b0;
      if (presenting) begin
        if (acc) begin
          push_expect(cur);
          dp     = 1'b1;
          waits  = 0;
          hwdata = cur.wdata;
          present_next(presenting, cur);
        end else if (!cur.trans[1]) begin
          present_next(presenting, cur);
        end
      end
    end
    if (cyc >= 300) begin
      errors++;
      $display("FAIL %s timeout: got %0d cycles want < 300", name, cyc);
    end
    htrans = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy_m !== 1'b1 || resp_m !== 1'b0 || rdata_m !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b resp=%0b rdata=%h want 1 0 0", rdy_m, resp_m, rdata_m);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    add_beat(2'b10, 1'b0, 16'h0000, 3'd2, '0, 1'b0, '0);
    run_beats("reset_read");
  endtask

  task automatic test_byte_lanes();
    sel = 0;
    add_beat(2'b10, 1'b1, 16'h0010, 3'd2, 32'h11223344, 1'b0, '0);
    add_beat(2'b10, 1'b1, 16'h0013, 3'd0, 32'hAA000000, 1'b0, '0);
    add_beat(2'b10, 1'b0, 16'h0010, 3'd2, '0, 1'b1, 32'hAA223344);
    add_beat(2'b10, 1'b1, 16'h0010, 3'd1, 32'h0000BEEF, 1'b0, '0);
    add_beat(2'b10, 1'b0, 16'h0010, 3'd2, '0, 1'b1, 32'hAA22BEEF);
    run_beats("byte_lanes");
  endtask

  task automatic test_back_to_back();
    logic [2:0]    sz;
    logic [AW-1:0] a;
    sel = 0;
    add_beat(2'b10, 1'b1, 16'h0100, 3'd2, 32'hCAFEF00D, 1'b0, '0);
    add_beat(2'b10, 1'b0, 16'h0100, 3'd2, '0, 1'b1, 32'hCAFEF00D);
    run_beats("back_to_back");
    // Random legal traffic on a small window so reads hit written words.
    for (int i = 0; i < 4; i++)
      add_beat(2'b10, 1'b1, 16'(16'h0200 + 4 * i), 3'd2, $urandom, 1'b0, '0);
    for (int i = 0; i < 24; i++) begin
      sz = 3'($urandom_range(0, 2));
      a  = 16'(16'h0200 + ($urandom_range(0, 15) & ~((1 << sz) - 1)));
      add_beat(2'b10, 1'($urandom_range(0, 1)), a, sz, $urandom, 1'b0, '0);
    end
    run_beats("random_stream");
  endtask

  task automatic test_wait_states();
    sel    = 1;
    add_beat(2'b10, 1'b1, 16'h0004, 3'd2, 32'h0BADCAFE, 1'b0, '0);
    add_beat(2'b10, 1'b0, 16'h0004, 3'd2, '0, 1'b1, 32'h0BADCAFE);
    run_beats("wait_read");
    hburst = 3'b001;
    add_beat(2'b10, 1'b1, 16'h0040, 3'd2, 32'h10000001, 1'b0, '0);
    add_beat(2'b11, 1'b1, 16'h0044, 3'd2, 32'h20000002, 1'b0, '0);
    add_beat(2'b11, 1'b1, 16'h0048, 3'd2, 32'h30000003, 1'b0, '0);
    add_beat(2'b11, 1'b1, 16'h004C, 3'd2, 32'h40000004, 1'b0, '0);
    add_beat(2'b10, 1'b0, 16'h0040, 3'd2, '0, 1'b1, 32'h10000001);
    add_beat(2'b11, 1'b0, 16'h0044, 3'd2, '0, 1'b1, 32'h20000002);
    add_beat(2'b11, 1'b0, 16'h0048, 3'd2, '0, 1'b1, 32'h30000003);
    add_beat(2'b11, 1'b0, 16'h004C, 3'd2, '0, 1'b1, 32'h40000004);
    run_beats("wait_incr4");
    hburst = 3'b000;
  endtask

  task automatic test_errors();
    sel = 0;
    add_beat(2'b10, 1'b1, 16'h0000, 3'd2, 32'h5A5A0001, 1'b0, '0);
    add_beat(2'b10, 1'b1, 16'h1000, 3'd2, 32'hFFFFFFFF, 1'b0, '0);
    add_beat(2'b10, 1'b0, 16'h0000, 3'd2, '0, 1'b1, 32'h5A5A0001);
    add_beat(2'b10, 1'b0, 16'h0002, 3'd2, '0, 1'b0, '0);
    add_beat(2'b10, 1'b0, 16'h0008, 3'd3, '0, 1'b0, '0);
    add_beat(2'b01, 1'b1, 16'h0000, 3'd2, 32'h77777777, 1'b0, '0);
    add_beat(2'b10, 1'b1, 16'h0FFC, 3'd2, 32'h600DF00D, 1'b0, '0);
    add_beat(2'b10, 1'b0, 16'h0FFC, 3'd2, '0, 1'b1, 32'h600DF00D);
    add_beat(2'b10, 1'b0, 16'h0000, 3'd2, '0, 1'b1, 32'h5A5A0001);
    run_beats("errors");
  endtask

  task automatic test_reset_mid_write();
    sel = 2;
    add_beat(2'b10, 1'b1, 16'h0020, 3'd2, 32'h01020304, 1'b0, '0);
    run_beats("mid_write_setup");
    haddr  = 16'h0020;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize  = 3'd2;
    @(posedge clk);
    #1;
    htrans = 2'b00;
    hwdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (rdy_m !== 1'b0) begin
      errors++;
      $display("FAIL mid_write_wait1: got rdy=%0b want 0", rdy_m);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy_m !== 1'b0) begin
      errors++;
      $display("FAIL mid_write_wait2: got rdy=%0b want 0", rdy_m);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_m !== 1'b1 || resp_m !== 1'b0 || rdata_m !== '0) begin
      errors++;
      $display("FAIL mid_write_after_reset: got rdy=%0b resp=%0b rdata=%h want 1 0 0",
               rdy_m, resp_m, rdata_m);
    end
    @(posedge clk);
    #1;
    add_beat(2'b10, 1'b0, 16'h0020, 3'd2, '0, 1'b1, 32'h01020304);
    run_beats("mid_write_readback");
  endtask

  // ---------------- main ----------------
  initial begin
    rst    = 1'b1;
    sel    = 0;
    haddr  = '0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hburst = 3'b000;
    hprot  = 4'b0011;
    hwdata = '0;
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached want bench completion");
    $fatal(1, "watchdog");
  end

endmodule
